reg_file_ops: RTL and testbench

Parametrised successor to the 4×8 accumulator register group in the datapath. It holds DEPTH registers of WIDTH bits with two combinational read ports (source s, destination d) and one write port addressed by the destination address. In-place write operations (load, increment, decrement, clear) update a carry flag and a per-register written mask. It sits between the instruction decoder and the ALU.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_alu_op.sv | 30 +++
 rtl/reg_file_ops.sv | 87 ++++++++
 tb/tb_reg_file_ops.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the accumulator register group: write-op encodings and default geometry.
package regfile_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/regfile_alu_op.sv
// Next-value and carry/borrow for one in-place register write.
// Shared by the commit path and the bypass path so they always agree.
module regfile_alu_op
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] nxt,
    output logic             cout
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        nxt  = '0;
        cout = 1'b0;
        case (op)
            OP_LOAD: nxt = i;
            // Extra top bit holds carry out of increment / borrow out of decrement
            OP_INC:  {cout, nxt} = {1'b0, r} + ONE;
            OP_DEC:  {cout, nxt} = {1'b0, r} - ONE;
            OP_CLR:  nxt = '0;
            default: nxt = '0;
        endcase
    end

endmodule

// File: rtl/reg_file_ops.sv
// DEPTH x WIDTH register group with two combinational read ports and one
// falling-edge write port performing load/inc/dec/clear in place.
module reg_file_ops
    import regfile_pkg::*;
#(
    parameter int          WIDTH      = DEF_WIDTH,
    parameter int          DEPTH      = DEF_DEPTH,
    parameter int          AW         = $clog2(DEPTH),
    parameter int          PRESET_IDX = 2,
    parameter logic [31:0] PRESET_VAL = 32'h60,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    raa,
    input  logic [AW-1:0]    rwba,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] d,
    output logic             cf,
    output logic [DEPTH-1:0] wmask
);

    localparam logic [AW:0]       DEPTH_W = DEPTH[AW:0];
    localparam logic [WIDTH-1:0]  PRESET  = PRESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] cur_r;
    logic [WIDTH-1:0] nxt_val;
    logic             nxt_cf;
    logic             in_range;
    logic             do_write;

    // we is a plain active-low level qualifier; there is no handshake.
    assign in_range = ({1'b0, rwba} < DEPTH_W);
    assign do_write = ~we & in_range;

    always_comb begin
        cur_r = '0;
        for (int n = 0; n < DEPTH; n++) begin
            if (AW'(n) == rwba) cur_r = regs[n];
        end
    end

    regfile_alu_op #(.WIDTH(WIDTH)) u_alu (
        .op   (op_t'(op)),
        .r    (cur_r),
        .i    (i),
        .nxt  (nxt_val),
        .cout (nxt_cf)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                regs[n] <= (n == PRESET_IDX) ? PRESET : '0;
            end
            cf    <= 1'b0;
            wmask <= '0;
        end else if (do_write) begin
            for (int n = 0; n < DEPTH; n++) begin
                if (AW'(n) == rwba) begin
                    regs[n]  <= nxt_val;
                    wmask[n] <= 1'b1;
                end
            end
            cf <= nxt_cf;
        end
    end

    // Out-of-range addresses match no entry and read 0
    always_comb begin
        s = '0;
        d = '0;
        for (int n = 0; n < DEPTH; n++) begin
            if (AW'(n) == raa)  s = regs[n];
            if (AW'(n) == rwba) d = regs[n];
        end
        if (BYPASS && do_write) begin
            if (raa == rwba) s = nxt_val;
            d = nxt_val;
        end
    end

endmodule

// File: tb/tb_reg_file_ops.sv
// Directed bench for reg_file_ops: default, 3-deep and bypass instances share one stimulus stream.
module tb_reg_file_ops;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [1:0] op;
    logic [1:0] raa;
    logic [1:0] rwba;
    logic [7:0] i;

    logic [7:0] u0_s, u0_d, u3_s, u3_d, ub_s, ub_d;
    logic       u0_cf, u3_cf, ub_cf;
    logic [3:0] u0_wmask, ub_wmask;
    logic [2:0] u3_wmask;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    reg_file_ops u0 (
        .clk(clk), .rst(rst), .we(we), .op(op), .raa(raa), .rwba(rwba), .i(i),
        .s(u0_s), .d(u0_d), .cf(u0_cf), .wmask(u0_wmask)
    );

    reg_file_ops #(.DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .we(we), .op(op), .raa(raa), .rwba(rwba), .i(i),
        .s(u3_s), .d(u3_d), .cf(u3_cf), .wmask(u3_wmask)
    );

    reg_file_ops #(.BYPASS(1'b1)) ub (
        .clk(clk), .rst(rst), .we(we), .op(op), .raa(raa), .rwba(rwba), .i(i),
        .s(ub_s), .d(ub_d), .cf(ub_cf), .wmask(ub_wmask)
    );

    // Clock: rises at 5, falls at 10, period 10
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        logic [31:0] e;
        exp_q.push_back(exp_v);
        e = exp_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    // One write on the next falling edge; leaves we high and rwba unchanged afterwards.
    task automatic do_op(input op_t o, input logic [1:0] addr, input logic [7:0] data);
        @(posedge clk);
        #1;
        we   = 1'b0;
        op   = o;
        rwba = addr;
        i    = data;
        @(negedge clk);
        #1;
        we = 1'b1;
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        we   = 1'b1;
        op   = OP_LOAD;
        raa  = 2'd0;
        rwba = 2'd1;
        i    = 8'h00;

        // Reset state
        #2;
        check("rst_s0", 32'(u0_s), 32'h00);
        check("rst_d1", 32'(u0_d), 32'h00);
        raa = 2'd3; rwba = 2'd2;
        #1;
        check("rst_s3", 32'(u0_s), 32'h00);
        check("rst_d2", 32'(u0_d), 32'h60);
        check("rst_cf", 32'(u0_cf), 32'h0);
        check("rst_wmask", 32'(u0_wmask), 32'h0);
        check("rst_wmask3", 32'(u3_wmask), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Async reset mid-high-phase clears a freshly loaded register
        do_op(OP_LOAD, 2'd0, 8'hA5);
        check("load_a5", 32'(u0_d), 32'hA5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_d0", 32'(u0_d), 32'h00);
        check("async_rst_wmask", 32'(u0_wmask), 32'h0);
        #1 rst = 1'b0;

        // Load / read
        do_op(OP_LOAD, 2'd1, 8'h3C);
        check("load_d1", 32'(u0_d), 32'h3C);
        check("load_wmask", 32'(u0_wmask), 32'h2);
        raa = 2'd1;
        #1;
        check("read_s1", 32'(u0_s), 32'h3C);
        i  = 8'hFF;
        op = OP_CLR;
        @(negedge clk);
        #1;
        check("we_high_hold", 32'(u0_d), 32'h3C);

        // Increment wrap
        do_op(OP_LOAD, 2'd0, 8'hFF);
        check("load_ff", 32'(u0_d), 32'hFF);
        do_op(OP_INC, 2'd0, 8'h00);
        check("inc_wrap_d", 32'(u0_d), 32'h00);
        check("inc_wrap_cf", 32'(u0_cf), 32'h1);
        do_op(OP_INC, 2'd0, 8'h00);
        check("inc_d", 32'(u0_d), 32'h01);
        check("inc_cf", 32'(u0_cf), 32'h0);
        check("inc_wmask", 32'(u0_wmask), 32'h3);

        // Decrement wrap; reg 3 is out of range for the 3-deep instance
        do_op(OP_CLR, 2'd3, 8'h55);
        check("clr_d3", 32'(u0_d), 32'h00);
        do_op(OP_DEC, 2'd3, 8'h00);
        check("dec_wrap_d", 32'(u0_d), 32'hFF);
        check("dec_wrap_cf", 32'(u0_cf), 32'h1);
        check("oor_d", 32'(u3_d), 32'h00);
        check("oor_cf", 32'(u3_cf), 32'h0);
        check("oor_wmask", 32'(u3_wmask), 32'h3);
        do_op(OP_LOAD, 2'd3, 8'h10);
        check("load_10_d", 32'(u0_d), 32'h10);
        check("load_10_cf", 32'(u0_cf), 32'h0);

        // Same source and destination address
        raa = 2'd2;
        do_op(OP_INC, 2'd2, 8'h00);
        check("same_s", 32'(u0_s), 32'h61);
        check("same_d", 32'(u0_d), 32'h61);
        check("same_s3", 32'(u3_s), 32'h61);
        check("same_d3", 32'(u3_d), 32'h61);
        check("same_wmask3", 32'(u3_wmask), 32'h7);
        check("same_wmask", 32'(u0_wmask), 32'hF);

        // Bypass vs. stored view before and after the falling edge
        raa = 2'd1;
        do_op(OP_LOAD, 2'd1, 8'h07);
        check("bp_pre_load", 32'(ub_d), 32'h07);
        @(posedge clk);
        #1;
        we = 1'b0; op = OP_INC; rwba = 2'd1; raa = 2'd1;
        #1;
        check("bp_s_early", 32'(ub_s), 32'h08);
        check("bp_d_early", 32'(ub_d), 32'h08);
        check("nobp_s_early", 32'(u0_s), 32'h07);
        check("nobp_d_early", 32'(u0_d), 32'h07);
        @(negedge clk);
        #1 we = 1'b1;
        #1;
        check("nobp_s_after", 32'(u0_s), 32'h08);
        check("nobp_d_after", 32'(u0_d), 32'h08);
        check("bp_d_after", 32'(ub_d), 32'h08);
        check("bp_cf_after", 32'(ub_cf), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
